// File: rtl/sha3_state_emitter_if.sv
`default_nettype none
// ============================================================================
// Module      : sha3_state_emitter_if
// Description : 64-bit lane stream carried from the SHA3 state emitter to the
//               result FIFO / readout logic.
//               odata  - current lane
//               ovalid - odata valid
//               oready - downstream ready
//               olast  - beat carries the final emitted lane
//               oindex - lane index of the current beat (0..24)
// Revision    : 1.0 - initial release
// ============================================================================
interface sha3_state_emitter_if;
   logic [63:0] odata;
   logic        ovalid;
   logic        oready;
   logic        olast;
   logic [4:0]  oindex;

   modport master (output odata, output ovalid, output olast, output oindex,
                   input  oready);
   modport slave  (input  odata, input  ovalid, input  olast, input  oindex,
                   output oready);
endinterface
`default_nettype wire

// File: rtl/sha3_state_emitter.sv
`default_nettype none
// ============================================================================
// Module      : sha3_state_emitter
// Description : Captures a full 5x5 Keccak state on istart and streams the
//               first OUT_LANES lanes out, one 64-bit lane per beat.
//               clk, rst_n           - clock, asynchronous active-low reset
//               isa..ise             - state rows a..e, columns 0..4
//               istart               - capture strobe
//               obusy                - a state is held and not fully emitted
//               odone                - one-cycle pulse after the final beat
//               ooverrun             - one-cycle pulse on a rejected istart
//               ostream (master)     - odata/ovalid/oready/olast/oindex
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_state_emitter #(
   parameter int OUT_LANES          = 25,
   parameter bit ALLOW_BACK_TO_BACK = 1'b1
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic [4:0][63:0]       isa,
   input  wire logic [4:0][63:0]       isb,
   input  wire logic [4:0][63:0]       isc,
   input  wire logic [4:0][63:0]       isd,
   input  wire logic [4:0][63:0]       ise,
   input  wire logic                   istart,
   output logic                        obusy,
   output logic                        odone,
   output logic                        ooverrun,
   sha3_state_emitter_if.master        ostream
);

   generate
      if (OUT_LANES < 1 || OUT_LANES > 25) begin : g_bad_out_lanes
         $fatal(1, "sha3_state_emitter: OUT_LANES=%0d outside 1..25", OUT_LANES);
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [63:0] lane_q [OUT_LANES];
   logic [63:0] lane_d [OUT_LANES];
   logic        odone_q, odone_d;
   logic        ooverrun_q, ooverrun_d;

   logic [24:0][63:0] in_lanes;
   logic              unused_lanes;
   logic              is_last;
   logic              hs;
   logic              capture;
   logic              emit;
   logic [63:0]       lane_mux;

   // Lane k = 5*row + col; row a sits in the lowest 320 bits.
   assign in_lanes = {ise, isd, isc, isb, isa};
   // Lanes at or above OUT_LANES are deliberately never registered.
   assign unused_lanes = ^in_lanes;

   assign emit    = (state_q == ST_EMIT);
   assign is_last = (idx_q == LAST_IDX);
   assign hs      = emit && ostream.oready;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lane_d     = lane_q;
      odone_d    = 1'b0;
      ooverrun_d = 1'b0;
      capture    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (istart) begin
               capture = 1'b1;
               idx_d   = 5'd0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (hs) begin
               if (is_last) begin
                  odone_d = 1'b1;
                  idx_d   = 5'd0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
            // Only a start landing exactly on the final handshake can be
            // taken; anything else would corrupt lanes still being emitted.
            if (istart) begin
               if (hs && is_last && ALLOW_BACK_TO_BACK) begin
                  capture = 1'b1;
                  idx_d   = 5'd0;
                  state_d = ST_EMIT;
               end else begin
                  ooverrun_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture) begin
         for (int k = 0; k < OUT_LANES; k++) begin
            lane_d[k] = in_lanes[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= 5'd0;
         lane_q     <= '{default: '0};
         odone_q    <= 1'b0;
         ooverrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lane_q     <= lane_d;
         odone_q    <= odone_d;
         ooverrun_q <= ooverrun_d;
      end
   end

   // Compare-based select keeps the 5-bit index legal for any array depth.
   always_comb begin
      lane_mux = '0;
      for (int k = 0; k < OUT_LANES; k++) begin
         if (idx_q == 5'(k)) begin
            lane_mux = lane_q[k];
         end
      end
   end

   assign ostream.ovalid = emit;
   assign ostream.odata  = emit ? lane_mux : 64'd0;
   assign ostream.oindex = idx_q;
   assign ostream.olast  = emit && is_last;
   assign obusy          = emit;
   assign odone          = odone_q;
   assign ooverrun       = ooverrun_q;

endmodule
`default_nettype wire

// File: doc/sha3_state_emitter.md
Name: sha3_state_emitter

Overview:
- Unload-side counterpart of the state capture path: latches a full 5x5 Keccak state (25 x 64-bit lanes) on a start strobe.
- Streams the first OUT_LANES lanes out, one lane per beat, over a 64-bit valid/ready interface.
- Sits between the SHA3 round core / scanner result path and the AXI-facing result FIFO or readout logic.

Parameters:
- OUT_LANES, 25, number of lanes emitted per state (1..25; e.g. 4 for a SHA3-256 digest). Any value outside 1..25 prints an error message and calls $finish at elaboration.
- ALLOW_BACK_TO_BACK, 1, when 1 a start coincident with the final beat's handshake is accepted; when 0 it is rejected as an overrun.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- isa, isb, isc, isd, ise  in  64 x5 each  state rows a..e, columns 0..4.
- istart  in  1  capture strobe; rows are sampled at the clk edge where istart=1 is accepted.
- obusy  out  1  1 while a state is held and not fully emitted.
- odata  out  64  current lane.
- ovalid  out  1  odata valid.
- oready  in  1  downstream ready.
- olast  out  1  1 on the beat carrying lane OUT_LANES-1.
- oindex  out  5  lane index of the current beat (0..24).
- odone  out  1  one-cycle pulse after the final beat handshakes.
- ooverrun  out  1  one-cycle pulse when istart is rejected.

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately regardless of state:
  - State goes to IDLE.
  - Lane buffer, index, ovalid, obusy, olast, odone and ooverrun all go to 0; odata=0.
  - Reset in the middle of an emission abandons the remaining beats; no odone pulse.
- Lane order: k = 5*row + col, rows a..e = 0..4. Lane 0 is isa[0], lane 4 is isa[4], lane 5 is isb[0], lane 24 is ise[4].
- Only lanes 0..OUT_LANES-1 are stored and emitted; the other lanes may be left unregistered.
- FSM states:
  - IDLE: ovalid=0, obusy=0. istart=1 captures all rows and sets index=0; next state EMIT.
  - EMIT: ovalid=1, obusy=1, odata=buffer[index], oindex=index, olast=(index==OUT_LANES-1).
    - Handshake is ovalid&oready. If olast=0, index increments.
    - If olast=1, odone pulses in the next cycle, and:
      - with istart=1 and ALLOW_BACK_TO_BACK=1: recapture, index=0, stay in EMIT with no gap cycle;
      - otherwise: go to IDLE.
- Latency: istart accepted at edge N gives ovalid=1 with lane 0 from edge N (registered outputs, visible cycle N+1).
- Minimum period between accepted starts is OUT_LANES cycles with oready held high.
- Stall: while oready=0, odata, oindex and olast hold stable and ovalid stays 1.
- The buffer is never modified during EMIT except by an accepted back-to-back recapture.
- istart in EMIT not coincident with a final handshake, or any coincident start when ALLOW_BACK_TO_BACK=0: ignored, the buffer is unchanged, ooverrun pulses for 1 cycle.
- OUT_LANES=1: every beat is both first and last (olast=1 continuously in EMIT).
- Index arithmetic is 5-bit; it never exceeds OUT_LANES-1, so there is no wrap beyond the final lane.

Test Plan:
- Reset, then istart with lane k = 64'h1000_0000_0000_0000 + k, OUT_LANES=25, oready=1 -> ovalid for 25 consecutive cycles, odata = 0x1000...0000..0x1000...0018 in order, olast only on oindex=24, odone 1 cycle after, obusy back to 0.
- OUT_LANES=4, oready toggling 1,0,0,1,... -> exactly 4 beats (isa[0], isa[1], isa[2], isa[3]); odata/oindex stable across every stall; olast on oindex=3.
- istart asserted at the beat with oindex=10 while emitting -> ooverrun pulse, remaining beats 11..24 still carry the original state values.
- ALLOW_BACK_TO_BACK=1: second istart (all lanes 64'hA5A5...) on the final handshake cycle -> next cycle oindex=0 with odata=64'hA5A5..., no ovalid gap, odone pulses once. With ALLOW_BACK_TO_BACK=0 the same stimulus -> ooverrun pulses, and the block returns to IDLE.
- rst_n asserted at oindex=7 with oready=1 -> ovalid/obusy drop without waiting for a clk edge, no odone pulse; a new istart after release restarts at oindex=0 with the new data.
- Elaborate with OUT_LANES=0 and with OUT_LANES=26 -> error message printed and simulation finishes.
